lsu_mem_sched: RTL and testbench

- Sequences the memory operations of one VLIW bundle (two LSU slots) onto a single shared memory port.
- Issues each op in slot order with a req/gnt/rvalid handshake and stalls issue while the bundle is in flight.
- Presents each completed op (raw load data plus rd/size/zero_ext/is_load) to the writeback stage, which performs extension and drives the register-file write enable.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align_check.sv | 16 +
 rtl/lsu_mem_sched.sv | 120 ++++++++++++
 tb/tb_lsu_mem_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU memory scheduler
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} sched_state_t;

    typedef struct packed {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        zero_ext;
        logic [4:0]  rd;
    } lsu_op_t;
endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: flags ops with an unencodable size or a misaligned address
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic        illegal
);
    logic unused_addr;

    assign unused_addr = ^addr[31:2];
    assign illegal = (size == 2'b11)
                  || (size == SZ_WORD && (zero_ext || addr[1:0] != 2'b00))
                  || (size == SZ_HALF && addr[0]);
endmodule

// File: rtl/lsu_mem_sched.sv
// lsu_mem_sched: sequences a two-slot VLIW bundle's memory ops onto one shared memory port
module lsu_mem_sched
    import lsu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       slot_valid,
    input  logic [1:0]       slot_is_load,
    input  logic [1:0][31:0] slot_addr,
    input  logic [1:0][31:0] slot_wdata,
    input  logic [1:0][1:0]  slot_size,
    input  logic [1:0]       slot_zero_ext,
    input  logic [1:0][4:0]  slot_rd,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [1:0]       mem_size,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             wb_valid,
    output logic             wb_slot,
    output logic             wb_is_load,
    output logic [4:0]       wb_rd,
    output logic [1:0]       wb_size,
    output logic             wb_zero_ext,
    output logic [31:0]      wb_data,
    output logic             err
);
    sched_state_t state, state_n;
    lsu_op_t      ops [2];
    lsu_op_t      in_op [2];
    lsu_op_t      cur_op, chk_op;
    logic         cur, pend1, drop, illegal, tmo, accept, more, done;
    logic [9:0]   cnt;

    always_comb begin
        for (int i = 0; i < 2; i++)
            in_op[i] = '{is_load: slot_is_load[i], addr: slot_addr[i], wdata: slot_wdata[i],
                         size: slot_size[i], zero_ext: slot_zero_ext[i], rd: slot_rd[i]};
    end

    assign cur_op = ops[cur];
    assign accept = state == IDLE && issue_valid && slot_valid != 2'b00;
    assign more   = state == NEXT && !cur && pend1;
    assign tmo    = cnt == 10'(MEM_TIMEOUT - 1);
    assign done   = (state == REQ && mem_gnt && !cur_op.is_load) || (state == WAIT && mem_rvalid);
    // Selection happens either at acceptance (lowest valid input slot) or in NEXT (slot 1)
    assign chk_op = state == IDLE ? in_op[~slot_valid[0]] : ops[1];

    lsu_align_check u_chk (
        .addr     (chk_op.addr),
        .size     (chk_op.size),
        .zero_ext (chk_op.zero_ext),
        .illegal  (illegal)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = illegal ? NEXT : REQ;
            REQ:  if (mem_gnt) state_n = cur_op.is_load ? WAIT : NEXT;
                  else if (tmo) state_n = NEXT;
            WAIT: if (mem_rvalid || tmo) state_n = NEXT;
            NEXT: state_n = more ? (illegal ? NEXT : REQ) : IDLE;
        endcase
    end

    assign stall     = state != IDLE;
    assign mem_req   = state == REQ;
    assign mem_we    = mem_req && !cur_op.is_load;
    assign mem_addr  = mem_req ? cur_op.addr : '0;
    assign mem_wdata = mem_req ? cur_op.wdata : '0;
    assign mem_size  = mem_req ? cur_op.size : '0;
    assign err       = state == NEXT && drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= 1'b0;
            pend1       <= 1'b0;
            ops         <= '{default: '0};
            cnt         <= '0;
            drop        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_slot     <= 1'b0;
            wb_is_load  <= 1'b0;
            wb_rd       <= '0;
            wb_size     <= '0;
            wb_zero_ext <= 1'b0;
            wb_data     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= state_n != state ? '0 : cnt + 10'd1;
            drop     <= (((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid)) && tmo)
                     || ((accept || more) && illegal);
            wb_valid <= done;
            if (accept) begin
                ops   <= in_op;
                pend1 <= slot_valid[1];
                cur   <= ~slot_valid[0];
            end
            if (more)
                cur <= 1'b1;
            if (done) begin
                wb_slot     <= cur;
                wb_is_load  <= cur_op.is_load;
                wb_rd       <= cur_op.rd;
                wb_size     <= cur_op.size;
                wb_zero_ext <= cur_op.zero_ext;
                wb_data     <= state == WAIT ? mem_rdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_sched.sv
// tb_lsu_mem_sched: scoreboard-driven bench for the LSU memory scheduler
module tb_lsu_mem_sched;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [1:0]       slot_valid = '0;
    logic [1:0]       slot_is_load = '0;
    logic [1:0][31:0] slot_addr = '0;
    logic [1:0][31:0] slot_wdata = '0;
    logic [1:0][1:0]  slot_size = '0;
    logic [1:0]       slot_zero_ext = '0;
    logic [1:0][4:0]  slot_rd = '0;
    logic             stall, mem_req, mem_we;
    logic [31:0]      mem_addr, mem_wdata;
    logic [1:0]       mem_size;
    logic             mem_gnt = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic [31:0]      mem_rdata = '0;
    logic             wb_valid, wb_slot, wb_is_load, wb_zero_ext, err;
    logic [4:0]       wb_rd;
    logic [1:0]       wb_size;
    logic [31:0]      wb_data;

    typedef struct {
        bit          slot;
        bit          is_load;
        logic [4:0]  rd;
        logic [1:0]  size;
        bit          zx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;

    lsu_mem_sched #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .slot_valid(slot_valid),
        .slot_is_load(slot_is_load), .slot_addr(slot_addr), .slot_wdata(slot_wdata),
        .slot_size(slot_size), .slot_zero_ext(slot_zero_ext), .slot_rd(slot_rd),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_slot(wb_slot), .wb_is_load(wb_is_load), .wb_rd(wb_rd), .wb_size(wb_size),
        .wb_zero_ext(wb_zero_ext), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_seen++;
            if (wb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 slot=%0d data=%h, required no writeback", wb_slot, wb_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (wb_slot !== e.slot || wb_is_load !== e.is_load || wb_size !== e.size || wb_data !== e.data
                        || (e.is_load && (wb_rd !== e.rd || wb_zero_ext !== e.zx))) begin
                        errors++;
                        $display("FAIL wb_fields: got slot=%0d load=%0d rd=%0d size=%b zx=%0d data=%h, required slot=%0d load=%0d rd=%0d size=%b zx=%0d data=%h",
                                 wb_slot, wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data,
                                 e.slot, e.is_load, e.rd, e.size, e.zx, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no $finish by 200000, required completion");
        $fatal(1);
    end

    task automatic drive(input bit iv, input bit g, input bit rv, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_valid = iv;
        mem_gnt = g;
        mem_rvalid = rv;
        mem_rdata = rdata;
        @(negedge clk);
    endtask

    task automatic clear_slots();
        slot_valid = '0;
        slot_is_load = '0;
        slot_addr = '0;
        slot_wdata = '0;
        slot_size = '0;
        slot_zero_ext = '0;
        slot_rd = '0;
    endtask

    task automatic set_slot(input int s, input bit ld, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit zx, input logic [4:0] rd);
        slot_valid[s] = 1'b1;
        slot_is_load[s] = ld;
        slot_addr[s] = a;
        slot_wdata[s] = wd;
        slot_size[s] = sz;
        slot_zero_ext[s] = zx;
        slot_rd[s] = rd;
    endtask

    task automatic test_reset();
        logic [112:0] outs;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {stall, mem_req, mem_we, mem_addr, mem_wdata, mem_size, wb_valid, wb_slot,
                wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data, err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
    endtask

    task automatic test_single_load();
        clear_slots();
        set_slot(0, 1, 32'h100, 32'h0, 2'b10, 0, 5'd5);
        exp_q.push_back('{1'b0, 1'b1, 5'd5, 2'b10, 1'b0, 32'hDEADBEEF});
        err_seen = 0;
        drive(1, 0, 0, 0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_accept_stall: got %b, required 0", stall); end
        drive(0, 1, 0, 0);
        checks++;
        if ({stall, mem_req, mem_we, mem_addr, mem_size} !== {1'b1, 1'b1, 1'b0, 32'h100, 2'b10}) begin
            errors++;
            $display("FAIL load_req: got stall=%b req=%b we=%b addr=%h size=%b, required 1 1 0 00000100 10",
                     stall, mem_req, mem_we, mem_addr, mem_size);
        end
        drive(0, 0, 1, 32'hDEADBEEF);
        checks++;
        if ({stall, mem_req, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL load_wait: got stall/req/wb=%b, required 100", {stall, mem_req, wb_valid});
        end
        drive(0, 0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL load_latency: got wb_valid=%b at N+3, required 1", wb_valid); end
        drive(0, 0, 0, 0);
        checks++;
        if ({stall, exp_q.size() == 0, err_seen == 0} !== 3'b011) begin
            errors++;
            $display("FAIL load_done: got stall=%b pending=%0d errs=%0d, required 0 0 0", stall, exp_q.size(), err_seen);
        end
    endtask

    task automatic test_two_ops();
        clear_slots();
        set_slot(0, 0, 32'h3, 32'hAB, 2'b00, 0, 5'd3);
        set_slot(1, 1, 32'h10, 32'h0, 2'b01, 1, 5'd7);
        exp_q.push_back('{1'b0, 1'b0, 5'd3, 2'b00, 1'b0, 32'h0});
        exp_q.push_back('{1'b1, 1'b1, 5'd7, 2'b01, 1'b1, 32'h0000BEEF});
        err_seen = 0;
        drive(1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(0, c == 2, 0, 0);
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_size} !== {1'b1, 1'b1, 32'h3, 32'hAB, 2'b00}) begin
                errors++;
                $display("FAIL store_req_hold%0d: got req=%b we=%b addr=%h wdata=%h size=%b, required 1 1 00000003 000000ab 00",
                         c, mem_req, mem_we, mem_addr, mem_wdata, mem_size);
            end
        end
        drive(0, 0, 0, 0);
        checks++;
        if ({mem_req, wb_valid, wb_slot} !== 3'b010) begin
            errors++;
            $display("FAIL store_wb: got req/wb/slot=%b, required 010", {mem_req, wb_valid, wb_slot});
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, c == 2, 0, 0);
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_size} !== {1'b1, 1'b0, 32'h10, 2'b01}) begin
                errors++;
                $display("FAIL lhu_req_hold%0d: got req=%b we=%b addr=%h size=%b, required 1 0 00000010 01",
                         c, mem_req, mem_we, mem_addr, mem_size);
            end
        end
        drive(0, 0, 1, 32'h0000BEEF);
        checks++;
        if ({mem_req, stall} !== 2'b01) begin errors++; $display("FAIL lhu_wait: got req/stall=%b, required 01", {mem_req, stall}); end
        drive(0, 0, 0, 0);
        checks++;
        if ({wb_valid, wb_slot} !== 2'b11) begin errors++; $display("FAIL lhu_wb: got wb/slot=%b, required 11", {wb_valid, wb_slot}); end
        drive(0, 0, 0, 0);
        checks++;
        if ({stall, exp_q.size() == 0, err_seen == 0} !== 3'b011) begin
            errors++;
            $display("FAIL two_ops_done: got stall=%b pending=%0d errs=%0d, required 0 0 0", stall, exp_q.size(), err_seen);
        end
    endtask

    task automatic test_misaligned();
        clear_slots();
        set_slot(0, 1, 32'h102, 32'h0, 2'b10, 0, 5'd4);
        set_slot(1, 1, 32'h21, 32'h0, 2'b00, 0, 5'd9);
        exp_q.push_back('{1'b1, 1'b1, 5'd9, 2'b00, 1'b0, 32'h00000080});
        err_seen = 0;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        checks++;
        if ({err, mem_req, stall} !== 3'b101) begin
            errors++;
            $display("FAIL misalign_skip: got err/req/stall=%b, required 101", {err, mem_req, stall});
        end
        drive(0, 1, 0, 0);
        checks++;
        if ({mem_req, mem_addr, mem_size, err} !== {1'b1, 32'h21, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL misalign_slot1_req: got req=%b addr=%h size=%b err=%b, required 1 00000021 00 0",
                     mem_req, mem_addr, mem_size, err);
        end
        drive(0, 0, 1, 32'h00000080);
        drive(0, 0, 0, 0);
        checks++;
        if ({wb_valid, wb_slot} !== 2'b11) begin errors++; $display("FAIL misalign_slot1_wb: got wb/slot=%b, required 11", {wb_valid, wb_slot}); end
        drive(0, 0, 0, 0);
        checks++;
        if (err_seen !== 1 || exp_q.size() != 0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_done: got errs=%0d pending=%0d stall=%b, required 1 0 0", err_seen, exp_q.size(), stall);
        end
    endtask

    task automatic test_timeout();
        clear_slots();
        set_slot(0, 1, 32'h200, 32'h0, 2'b10, 0, 5'd6);
        err_seen = 0;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0);
            checks++;
            if ({stall, mem_req, err} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait%0d: got stall/req/err=%b, required 100", c, {stall, mem_req, err});
            end
        end
        drive(0, 0, 0, 0);
        checks++;
        if ({err, wb_valid} !== 2'b10) begin errors++; $display("FAIL timeout_err: got err/wb=%b, required 10", {err, wb_valid}); end
        drive(0, 0, 1, 32'h12345678);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL timeout_idle: got stall=%b, required 0", stall); end
        drive(0, 0, 0, 0);
        checks++;
        if (wb_valid !== 1'b0 || err_seen !== 1) begin
            errors++;
            $display("FAIL timeout_late_rvalid: got wb=%b errs=%0d, required 0 1", wb_valid, err_seen);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [112:0] outs;
        clear_slots();
        set_slot(0, 1, 32'h300, 32'h0, 2'b10, 0, 5'd2);
        err_seen = 0;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        checks++;
        if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL rst_pre_wait: got stall/req=%b, required 10", {stall, mem_req}); end
        rst = 1'b1;
        clear_slots();
        set_slot(0, 0, 32'h40, 32'h1234, 2'b10, 0, 5'd0);
        exp_q.push_back('{1'b0, 1'b0, 5'd0, 2'b10, 1'b0, 32'h0});
        drive(1, 0, 1, 32'hCAFEF00D);
        outs = {stall, mem_req, mem_we, mem_addr, mem_wdata, mem_size, wb_valid, wb_slot,
                wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data, err};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rst_wait_outputs: got %h, required 0", outs); end
        drive(0, 1, 0, 0);
        checks++;
        if ({wb_valid, mem_req, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b1, 32'h40, 32'h1234}) begin
            errors++;
            $display("FAIL rst_new_bundle: got wb=%b req=%b we=%b addr=%h wdata=%h, required 0 1 1 00000040 00001234",
                     wb_valid, mem_req, mem_we, mem_addr, mem_wdata);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL rst_new_wb: got wb_valid=%b, required 1", wb_valid); end
        drive(0, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0 || err_seen !== 0) begin
            errors++;
            $display("FAIL rst_done: got pending=%0d errs=%0d, required 0 0", exp_q.size(), err_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_two_ops();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
